display_scan_ctrl: RTL

Time-multiplexed scan controller that shares one hex-to-seven-segment decode path across `N_DIGITS` common-anode digits. Paces the scan with a clock prescaler, selects one digit per slot, and drives active-low segment and anode lines. Buffers host writes and applies them only at frame boundaries, so the display never tears. Sits between the board's value-producing logic and the seven-segment pins.

---
 rtl/display_pkg.sv | 32 +++
 rtl/scan_prescaler.sv | 29 ++
 rtl/display_scan_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and the hex-to-seven-segment decode table for the display
// scan controller. Segment vectors are active-low, bit 6 = a ... bit 0 = g.
package display_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex nibble to active-low segment pattern (b and d are lowercase glyphs).
  function automatic seg_t hex_to_seg(input nibble_t n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;  // 4'hF
    endcase
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts DIV cycles per slot while enabled and flags
// the last cycle of each slot. The count freezes while disabled.
module scan_prescaler #(
  parameter int DIV = 50000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          tick,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  assign tick = en && (cnt == CNT_LAST);

  // Free-running slot counter, wraps at DIV-1, holds while disabled.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller for N_DIGITS common-anode
// digits. Host writes are buffered and committed only at frame boundaries
// (or immediately while the scan is disabled) so a frame never tears.
// Outputs are registered; each slot starts with a one-cycle dark guard.
// Optional build macro: DISPLAY_SCAN_LZB_EN enables leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  output seg_t                  seg_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  pending_o,
  output logic                  frame_o
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic                tick;
  logic [CW-1:0]       slot_cnt;
  logic [IW-1:0]       idx;
  logic                frame_tick;
  logic                commit_window;

  nibble_t             data_nib    [N_DIGITS];
  nibble_t             pend_nib    [N_DIGITS];
  logic [N_DIGITS-1:0] pend_blank;
  nibble_t             shadow_nib  [N_DIGITS];
  logic [N_DIGITS-1:0] shadow_blank;

  logic [N_DIGITS-1:0] anode_sel;
  logic                suppress;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en_i),
    .tick (tick),
    .cnt  (slot_cnt)
  );

  // The slot tick can only fire on the final count of a slot.
  assert property (@(posedge clk) disable iff (!rst_n)
                   tick |-> (slot_cnt == CW'(DIV - 1)));

  assign frame_tick    = tick && (idx == IDX_LAST);
  // Commits may land at a frame boundary or anywhere while the display is dark.
  assign commit_window = frame_tick || !en_i;

  // Digit index advances once per slot and wraps after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Split the host word into per-digit nibbles.
  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    data_nib = '{default: '0};
    for (int k = 0; k < N_DIGITS; k++) begin
      data_nib[k] = data_i[4*k +: 4];
    end
  end

  // Pending payload capture; its contents only matter while pending_o is set.
  // NOTE: this storage has no reset on purpose -- the valid flag (pending_o)
  // qualifies it, so resetting the payload would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load_i) begin
      pend_nib   <= data_nib;
      pend_blank <= blank_i;
    end
  end

  // Pending valid flag and shadow (displayed) buffer; newest write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_o    <= 1'b0;
      shadow_nib   <= '{default: '0};
      shadow_blank <= '0;
    end else if (load_i && commit_window) begin
      pending_o    <= 1'b0;
      shadow_nib   <= data_nib;
      shadow_blank <= blank_i;
    end else if (load_i) begin
      pending_o    <= 1'b1;
    end else if (pending_o && commit_window) begin
      pending_o    <= 1'b0;
      shadow_nib   <= pend_nib;
      shadow_blank <= pend_blank;
    end
  end

  // Active-low one-hot anode for the current digit, plus its blanking decision.
  always_comb begin
    anode_sel      = '1;
    anode_sel[idx] = 1'b0;
    suppress       = shadow_blank[idx];
`ifdef DISPLAY_SCAN_LZB_EN
    begin
      logic significant_above;
      significant_above = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
        if ((k >= int'(idx)) && (shadow_nib[k] != '0) && !shadow_blank[k]) begin
          significant_above = 1'b1;
        end
      end
      // Digit 0 always shows, so a zero value still reads "0".
      if ((idx != '0) && !significant_above) begin
        suppress = 1'b1;
      end
    end
`endif
  end

  // Output registers: dark while disabled or on the guard cycle after a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o    <= '1;
      seg_o   <= SEG_BLANK;
      frame_o <= 1'b0;
    end else begin
      frame_o <= frame_tick;
      if (!en_i || tick) begin
        an_o  <= '1;
        seg_o <= SEG_BLANK;
      end else begin
        an_o  <= anode_sel;
        seg_o <= suppress ? SEG_BLANK : hex_to_seg(shadow_nib[idx]);
      end
    end
  end

endmodule
